// File: rtl/grey_pkg.sv
// grey_pkg
// Shared constants for the grey-digit display path: the ten legal grey
// decade codes, the seven-segment patterns (bit0 = segment a, active-high),
// and the decode helpers used by grey_dig_sync and grey_disp.
package grey_pkg;

   localparam logic [4:0] GREY_0 = 5'b11000;
   localparam logic [4:0] GREY_1 = 5'b11001;
   localparam logic [4:0] GREY_2 = 5'b10001;
   localparam logic [4:0] GREY_3 = 5'b10011;
   localparam logic [4:0] GREY_4 = 5'b00011;
   localparam logic [4:0] GREY_5 = 5'b00111;
   localparam logic [4:0] GREY_6 = 5'b00110;
   localparam logic [4:0] GREY_7 = 5'b01110;
   localparam logic [4:0] GREY_8 = 5'b01100;
   localparam logic [4:0] GREY_9 = 5'b11100;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Returns {valid, bcd[3:0]}; valid = 0 for any code outside the table.
   function automatic logic [4:0] f_grey2bcd(input logic [4:0] code);
      logic [4:0] r;
      case (code)
         GREY_0:  r = {1'b1, 4'd0};
         GREY_1:  r = {1'b1, 4'd1};
         GREY_2:  r = {1'b1, 4'd2};
         GREY_3:  r = {1'b1, 4'd3};
         GREY_4:  r = {1'b1, 4'd4};
         GREY_5:  r = {1'b1, 4'd5};
         GREY_6:  r = {1'b1, 4'd6};
         GREY_7:  r = {1'b1, 4'd7};
         GREY_8:  r = {1'b1, 4'd8};
         GREY_9:  r = {1'b1, 4'd9};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   function automatic logic [6:0] f_bcd2seg(input logic [3:0] bcd);
      logic [6:0] r;
      case (bcd)
         4'd0:    r = SEG_0;
         4'd1:    r = SEG_1;
         4'd2:    r = SEG_2;
         4'd3:    r = SEG_3;
         4'd4:    r = SEG_4;
         4'd5:    r = SEG_5;
         4'd6:    r = SEG_6;
         4'd7:    r = SEG_7;
         4'd8:    r = SEG_8;
         4'd9:    r = SEG_9;
         default: r = SEG_BLANK;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/grey_disp_if.sv
// grey_disp_if
// Bundles the grey-digit inputs, error clear and display outputs of grey_disp.
//   master : drives i_grey / i_err_clr, observes the display outputs
//   slave  : the grey_disp side
interface grey_disp_if #(
   parameter int pDIGITS = 4
);
   logic [5*pDIGITS-1:0] i_grey;
   logic                 i_err_clr;
   logic [4*pDIGITS-1:0] o_bcd;
   logic [6:0]           o_seg;
   logic                 o_dp;
   logic [pDIGITS-1:0]   o_an;
   logic                 o_err;

   modport master (
      output i_grey, i_err_clr,
      input  o_bcd, o_seg, o_dp, o_an, o_err
   );

   modport slave (
      input  i_grey, i_err_clr,
      output o_bcd, o_seg, o_dp, o_an, o_err
   );
endinterface

// File: rtl/grey_dig_sync.sv
// grey_dig_sync
// One grey digit: two-flop synchroniser (s1, s2), compare stage s3, decode
// and the digit's BCD register. A code is only acted on once it has been
// seen identical in s2 and s3, so a code present for a single sampled cycle
// is neither decoded nor flagged.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_grey         : 5-bit grey code, possibly from another clock domain
//   o_bcd          : last stable legal digit value
//   o_err_set      : stable illegal code seen this cycle (combinational)
module grey_dig_sync
   import grey_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_grey,
   output logic [3:0] o_bcd,
   output logic       o_err_set
);

   logic [4:0] s1, s2, s3;
   logic [4:0] dec;
   logic       stable;

   assign dec       = f_grey2bcd(s2);
   assign stable    = (s2 == s3);
   assign o_err_set = stable & ~dec[4];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1    <= GREY_0;
         s2    <= GREY_0;
         s3    <= GREY_0;
         o_bcd <= 4'd0;
      end else begin
         s1 <= i_grey;
         s2 <= s1;
         s3 <= s2;
         if (stable && dec[4]) begin
            o_bcd <= dec[3:0];
         end
      end
   end

endmodule

// File: rtl/grey_disp.sv
// grey_disp
// Takes a chain of grey decade digits, decodes each to BCD and scans them
// onto a multiplexed 7-segment display with optional leading-zero blanking.
// A sticky error flag latches any stable illegal code.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus.i_grey     : pDIGITS x 5-bit grey codes, digit 0 in the LSBs
//   bus.i_err_clr  : clears o_err (a new error in the same cycle wins)
//   bus.o_bcd      : decoded digits, 4 bits each
//   bus.o_seg      : segments a..g for the selected digit
//   bus.o_dp       : error indicator on digit 0
//   bus.o_an       : one-hot digit select
//   bus.o_err      : sticky illegal-code flag
module grey_disp
   import grey_pkg::*;
#(
   parameter int pDIGITS   = 4,
   parameter int pSCAN_DIV = 1000,
   parameter int pBLANK    = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   grey_disp_if.slave  bus
);

   localparam int IW = (pDIGITS > 1) ? $clog2(pDIGITS) : 1;
   localparam int PW = $clog2(pSCAN_DIV);
   localparam logic [IW-1:0] LAST_IDX = IW'(pDIGITS - 1);
   localparam logic [PW-1:0] LAST_CNT = PW'(pSCAN_DIV - 1);

   wire  [4*pDIGITS-1:0] bcd;
   wire  [pDIGITS-1:0]   err_set;

   logic                 err;
   logic [PW-1:0]        presc;
   logic [IW-1:0]        idx;
   logic [pDIGITS-1:0]   zero_from;
   logic [3:0]           cur_digit;
   logic                 blank;
   logic [6:0]           seg;
   logic [pDIGITS-1:0]   an;

   for (genvar k = 0; k < pDIGITS; k++) begin : g_dig
      grey_dig_sync u_dig (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_grey    (bus.i_grey[5*k +: 5]),
         .o_bcd     (bcd[4*k +: 4]),
         .o_err_set (err_set[k])
      );
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         err   <= 1'b0;
         presc <= '0;
         idx   <= '0;
      end else begin
         err <= (|err_set) | (err & ~bus.i_err_clr);
         if (presc == LAST_CNT) begin
            presc <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // zero_from[k]: digits k..pDIGITS-1 are all zero, i.e. digit k is a
   // leading zero.
   always_comb begin
      zero_from = '0;
      for (int k = 0; k < pDIGITS; k++) begin
         logic z;
         z = 1'b1;
         for (int j = k; j < pDIGITS; j++) begin
            if (bcd[4*j +: 4] != 4'd0) z = 1'b0;
         end
         zero_from[k] = z;
      end
   end

   always_comb begin
      cur_digit = bcd[4*int'(idx) +: 4];
      blank     = (pBLANK != 0) && (idx != '0) && zero_from[idx];
      seg       = blank ? SEG_BLANK : f_bcd2seg(cur_digit);
      an        = '0;
      an[idx]   = 1'b1;
   end

   assign bus.o_bcd = bcd;
   assign bus.o_seg = seg;
   assign bus.o_an  = an;
   assign bus.o_err = err;
   assign bus.o_dp  = err & (idx == '0);

endmodule

// File: tb/tb_grey_disp.sv
module tb_grey_disp;
   localparam int ND  = 4;
   localparam int DIV = 4;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   grey_disp_if #(.pDIGITS(ND)) bus ();

   grey_disp #(.pDIGITS(ND), .pSCAN_DIV(DIV), .pBLANK(1)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [4*ND-1:0] bcd;
      logic [6:0]      seg;
      logic            dp;
      logic [ND-1:0]   an;
      logic            err;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [4:0] code_tab [10] = '{5'b11000, 5'b11001, 5'b10001, 5'b10011, 5'b00011,
                                 5'b00111, 5'b00110, 5'b01110, 5'b01100, 5'b11100};
   logic [6:0] seg_tab  [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Reference model: samples seen at recent edges (0 = newest), digit values,
   // error flag and edges elapsed since the last reset edge.
   logic [4:0] hist [4][ND];
   int         mbcd [ND];
   logic       merr;
   int         t;
   logic [5*ND-1:0] g_cur;

   function automatic int decode(input logic [4:0] c);
      for (int i = 0; i < 10; i++) if (code_tab[i] == c) return i;
      return -1;
   endfunction

   task automatic model_edge(input logic [5*ND-1:0] g, input logic clr, input logic rst_n);
      exp_t e;
      int   idx;
      logic set;
      logic lead;
      if (!rst_n) begin
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < ND; k++) hist[j][k] = 5'b11000;
         for (int k = 0; k < ND; k++) mbcd[k] = 0;
         merr = 1'b0;
         t    = 0;
      end else begin
         for (int j = 3; j > 0; j--)
            for (int k = 0; k < ND; k++) hist[j][k] = hist[j-1][k];
         for (int k = 0; k < ND; k++) hist[0][k] = g[5*k +: 5];
         // A code is acted on when it was seen at two consecutive edges,
         // two and three edges ago.
         set = 1'b0;
         for (int k = 0; k < ND; k++) begin
            if (hist[2][k] == hist[3][k]) begin
               if (decode(hist[2][k]) >= 0) mbcd[k] = decode(hist[2][k]);
               else set = 1'b1;
            end
         end
         merr = set | (merr & ~clr);
         t++;
      end
      idx = (t / DIV) % ND;
      for (int k = 0; k < ND; k++) e.bcd[4*k +: 4] = 4'(mbcd[k]);
      lead = 1'b1;
      for (int k = idx; k < ND; k++) if (mbcd[k] != 0) lead = 1'b0;
      e.seg = (idx > 0 && lead) ? 7'h00 : seg_tab[mbcd[idx]];
      e.an  = ND'(1) << idx;
      e.err = merr;
      e.dp  = merr && (idx == 0);
      q.push_back(e);
   endtask

   task automatic cyc(input logic [5*ND-1:0] g, input logic clr, input logic rst_n);
      bus.i_grey    = g;
      bus.i_err_clr = clr;
      i_rst_n       = rst_n;
      model_edge(g, clr, rst_n);
      @(posedge i_clk);
      #1;
   endtask

   task automatic hold(input logic [5*ND-1:0] g, input int n);
      for (int i = 0; i < n; i++) cyc(g, 1'b0, 1'b1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a new display state.
   always @(negedge i_clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("o_bcd", 32'(bus.o_bcd), 32'(e.bcd));
         chk("o_seg", 32'(bus.o_seg), 32'(e.seg));
         chk("o_dp",  32'(bus.o_dp),  32'(e.dp));
         chk("o_an",  32'(bus.o_an),  32'(e.an));
         chk("o_err", 32'(bus.o_err), 32'(e.err));
      end
   end

   function automatic logic [5*ND-1:0] pack4(input logic [4:0] d3, input logic [4:0] d2,
                                             input logic [4:0] d1, input logic [4:0] d0);
      return {d3, d2, d1, d0};
   endfunction

   initial begin
      logic [4:0] z;
      logic [4:0] d [ND];
      logic       clr;
      logic       rst_n;
      z = 5'b11000;
      bus.i_grey    = pack4(z, z, z, z);
      bus.i_err_clr = 1'b0;
      #1;

      // Reset, then scan all digits with everything zero (upper digits blank).
      for (int i = 0; i < 3; i++) cyc(pack4(z, z, z, z), 1'b0, 1'b0);
      hold(pack4(z, z, z, z), 20);

      // Digit 0 -> 1.
      hold(pack4(z, z, z, 5'b11001), 8);

      // Reset mid-scan, then a fresh dwell.
      cyc(pack4(z, z, z, 5'b11001), 1'b0, 1'b0);
      hold(pack4(z, z, z, 5'b11001), 10);

      // Illegal code on digit 1; clear while still illegal; restore 4; clear.
      hold(pack4(z, z, 5'b10101, 5'b11001), 6);
      cyc(pack4(z, z, 5'b10101, 5'b11001), 1'b1, 1'b1);
      hold(pack4(z, z, 5'b10101, 5'b11001), 2);
      hold(pack4(z, z, 5'b00011, 5'b11001), 5);
      cyc(pack4(z, z, 5'b00011, 5'b11001), 1'b1, 1'b1);
      hold(pack4(z, z, 5'b00011, 5'b11001), 4);

      // One-sample glitch on digit 0 between 1 and 9.
      hold(pack4(z, z, 5'b00011, 5'b11001), 4);
      cyc(pack4(z, z, 5'b00011, 5'b11101), 1'b0, 1'b1);
      hold(pack4(z, z, 5'b00011, 5'b11100), 6);

      // Digits 0,0,5,0 with the error flag set: blanking and decimal point.
      hold(pack4(z, z, 5'b00111, z), 6);
      hold(pack4(5'b11111, z, 5'b00111, z), 3);
      hold(pack4(z, z, 5'b00111, z), 20);

      // Randomised traffic.
      for (int k = 0; k < ND; k++) d[k] = z;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < ND; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)      d[k] = code_tab[$urandom_range(0, 9)];
            else if (r < 12) d[k] = 5'($urandom);
         end
         clr   = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         cyc({d[3], d[2], d[1], d[0]}, clr, rst_n);
      end

      @(negedge i_clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
